// File: rtl/id_buf_stage.sv
// id_buf_stage: decode stage with an IF->EX instruction queue,
// register file with write-back bypass and load-use bubbles.
module id_buf_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   flush,
    input  logic                   wb_en,
    input  logic [4:0]             wb_adr,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [10:0]            out_cls,
    output logic [2:0]             out_funct3,
    output logic                   out_f7b5,
    output logic [4:0]             out_rd,
    output logic                   out_wbk,
    output logic [XLEN-1:0]        out_rs1_data,
    output logic [XLEN-1:0]        out_rs2_data,
    output logic [XLEN-1:0]        out_imm,
    output logic                   out_illegal,
    output logic                   hz_stall,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int PW  = $clog2(DEPTH);
    localparam int RW  = $clog2(NREG);
    localparam bit RVE = (NREG == 16);

    localparam int C_LUI   = 0;
    localparam int C_AUIPC = 1;
    localparam int C_JAL   = 2;
    localparam int C_JALR  = 3;
    localparam int C_BR    = 4;
    localparam int C_LD    = 5;
    localparam int C_ST    = 6;
    localparam int C_ALUI  = 7;
    localparam int C_ALU   = 8;
    localparam int C_FENCE = 9;
    localparam int C_SYS   = 10;

    logic [31:0]     q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            head_valid;

    assign in_ready   = (fifo_cnt < (PW+1)'(DEPTH)) & ~flush;
    assign push       = in_valid & in_ready;
    assign head_valid = (fifo_cnt != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= in_inst;
            q_pc[wr_ptr]   <= in_pc;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    logic [31:0]     hi;
    logic [XLEN-1:0] hpc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [10:0]     cls;

    assign hi  = q_inst[rd_ptr];
    assign hpc = q_pc[rd_ptr];
    assign rs1 = hi[19:15];
    assign rs2 = hi[24:20];
    assign rd  = hi[11:7];

    always_comb begin
        cls = '0;
        if (hi[1:0] == 2'b11) begin
            case (hi[6:2])
                5'b01101: cls[C_LUI]   = 1'b1;
                5'b00101: cls[C_AUIPC] = 1'b1;
                5'b11011: cls[C_JAL]   = 1'b1;
                5'b11001: cls[C_JALR]  = 1'b1;
                5'b11000: cls[C_BR]    = 1'b1;
                5'b00000: cls[C_LD]    = 1'b1;
                5'b01000: cls[C_ST]    = 1'b1;
                5'b00100: cls[C_ALUI]  = 1'b1;
                5'b01100: cls[C_ALU]   = 1'b1;
                5'b00011: cls[C_FENCE] = 1'b1;
                5'b11100: cls[C_SYS]   = 1'b1;
                default:  cls = '0;
            endcase
        end
    end

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            cls[C_LUI], cls[C_AUIPC]:
                imm32 = {hi[31:12], 12'b0};
            cls[C_JAL]:
                imm32 = {{12{hi[31]}}, hi[19:12],
                         hi[20], hi[30:21], 1'b0};
            cls[C_JALR], cls[C_LD], cls[C_ALUI],
            cls[C_FENCE], cls[C_SYS]:
                imm32 = {{20{hi[31]}}, hi[31:20]};
            cls[C_ST]:
                imm32 = {{20{hi[31]}}, hi[31:25], hi[11:7]};
            cls[C_BR]:
                imm32 = {{20{hi[31]}}, hi[7],
                         hi[30:25], hi[11:8], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic bad_reg;
    logic illegal;
    logic wbk;

    assign use_rs1 = ~(cls[C_LUI] | cls[C_AUIPC] | cls[C_JAL]);
    assign use_rs2 = cls[C_BR] | cls[C_ST] | cls[C_ALU];
    assign use_rd  = (|cls) & ~(cls[C_ST] | cls[C_BR] | cls[C_FENCE]);

    // RV32E only has x0..x15, so bit 4 of any used index traps.
    assign bad_reg = RVE & ((use_rs1 & rs1[4]) |
                            (use_rs2 & rs2[4]) |
                            (use_rd  & rd[4]));
    assign illegal = (cls == '0) | bad_reg;
    assign wbk     = ~(cls[C_ST] | cls[C_BR] | cls[C_FENCE]) &
                     (rd != '0);

    logic [XLEN-1:0] regs [NREG];
    logic            wb_ok;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    assign wb_ok = RVE ? ~wb_adr[4] : 1'b1;

    always_ff @(posedge clk) begin
        if (wb_en && wb_adr != '0 && wb_ok)
            regs[wb_adr[RW-1:0]] <= wb_data;
    end

    always_comb begin
        rs1_data = regs[rs1[RW-1:0]];
        if (rs1 == '0)
            rs1_data = '0;
        else if (wb_en && wb_adr == rs1)
            rs1_data = wb_data;
    end

    always_comb begin
        rs2_data = regs[rs2[RW-1:0]];
        if (rs2 == '0)
            rs2_data = '0;
        else if (wb_en && wb_adr == rs2)
            rs2_data = wb_data;
    end

    logic hazard;
    logic issue;

    assign hazard = head_valid & out_valid & out_cls[C_LD] &
                    (out_rd != '0) &
                    ((use_rs1 & (rs1 == out_rd)) |
                     (use_rs2 & (rs2 == out_rd)));
    assign issue    = head_valid & (~out_valid | out_ready) &
                      ~hazard & ~flush;
    assign pop      = issue;
    assign hz_stall = hazard & out_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_cls      <= '0;
            out_funct3   <= '0;
            out_f7b5     <= 1'b0;
            out_rd       <= '0;
            out_wbk      <= 1'b0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_pc       <= hpc;
            out_cls      <= cls;
            out_funct3   <= hi[14:12];
            out_f7b5     <= hi[30];
            out_rd       <= rd;
            out_wbk      <= wbk;
            out_rs1_data <= rs1_data;
            out_rs2_data <= rs2_data;
            out_imm      <= imm;
            out_illegal  <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_buf_stage.sv
// tb_id_buf_stage: random and directed stimulus against a
// queue-based reference model of the decode stage.
module tb_id_buf_stage;

    localparam int DEPTH = 4;
    localparam int LUI = 0, AUIPC = 1, JAL = 2, JALR = 3, BR = 4;
    localparam int LD = 5, ST = 6, ALUI = 7, ALU = 8, FENCE = 9;
    localparam int SYS = 10;
    localparam logic [6:0] OPS [11] = '{
        7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
        7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, wb_data, out_pc;
    logic [4:0]  wb_adr, out_rd;
    logic [10:0] out_cls;
    logic [2:0]  out_funct3;
    logic        out_f7b5, out_wbk, out_illegal, hz_stall;
    logic [31:0] out_rs1_data, out_rs2_data, out_imm;
    logic [2:0]  fifo_cnt;

    logic        e_in_ready, e_out_valid, e_f7b5, e_wbk, e_illegal;
    logic        e_hz_stall;
    logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
    logic [10:0] e_cls;
    logic [2:0]  e_funct3, e_fifo_cnt;
    logic [4:0]  e_rd;

    id_buf_stage #(.XLEN(32), .DEPTH(DEPTH), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_adr(wb_adr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_cls(out_cls),
        .out_funct3(out_funct3), .out_f7b5(out_f7b5),
        .out_rd(out_rd), .out_wbk(out_wbk),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_illegal(out_illegal),
        .hz_stall(hz_stall), .fifo_cnt(fifo_cnt));

    id_buf_stage #(.XLEN(32), .DEPTH(DEPTH), .NREG(16)) dut_e (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(e_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_adr(wb_adr), .wb_data(wb_data),
        .out_valid(e_out_valid), .out_ready(out_ready),
        .out_pc(e_pc), .out_cls(e_cls),
        .out_funct3(e_funct3), .out_f7b5(e_f7b5),
        .out_rd(e_rd), .out_wbk(e_wbk),
        .out_rs1_data(e_rs1), .out_rs2_data(e_rs2),
        .out_imm(e_imm), .out_illegal(e_illegal),
        .hz_stall(e_hz_stall), .fifo_cnt(e_fifo_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_stall = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mregs [32];
    bit          ov;
    logic [31:0] o_pc, o_r1, o_r2, o_imm;
    logic [10:0] o_cls;
    logic [2:0]  o_f3;
    logic [4:0]  o_rd;
    logic        o_f7, o_wbk, o_ill;

    function automatic void decode(input logic [31:0] i,
                                   output int c,
                                   output logic [31:0] imm);
        c = -1;
        for (int k = 0; k < 11; k++)
            if (i[6:0] == OPS[k]) c = k;
        case (c)
            LUI, AUIPC: imm = {i[31:12], 12'h000};
            JAL: imm = 32'($signed({i[31], i[19:12], i[20],
                                    i[30:21], 1'b0}));
            JALR, LD, ALUI, FENCE, SYS:
                imm = 32'($signed(i[31:20]));
            ST:  imm = 32'($signed({i[31:25], i[11:7]}));
            BR:  imm = 32'($signed({i[31], i[7], i[30:25],
                                    i[11:8], 1'b0}));
            default: imm = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rf(input logic [4:0] a,
                                       input bit we,
                                       input logic [4:0] wa,
                                       input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    task automatic cycle(input bit iv, input logic [31:0] inst,
                         input bit ordy, input bit fl, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd);
        bit have, haz, iss, push, u1, u2, rdy;
        int c;
        logic [31:0] imm, hd;
        ent_t e;
        @(negedge clk);
        in_valid = iv; in_inst = inst; in_pc = $urandom;
        out_ready = ordy; flush = fl;
        wb_en = we; wb_adr = wa; wb_data = wd;
        #1;
        have = q.size() > 0;
        haz = 0;
        if (have) begin
            hd = q[0].inst;
            decode(hd, c, imm);
            u1 = !(c inside {LUI, AUIPC, JAL});
            u2 = c inside {BR, ST, ALU};
            haz = ov && o_cls[LD] && o_rd != 0 &&
                  ((u1 && hd[19:15] == o_rd) ||
                   (u2 && hd[24:20] == o_rd));
        end
        iss = have && (!ov || ordy) && !haz && !fl;
        rdy = (q.size() < DEPTH) && !fl;
        push = iv && rdy;
        check("in_ready", in_ready, rdy);
        check("hz_stall", hz_stall, haz && ordy && !fl);
        check("fifo_cnt_pre", fifo_cnt, q.size());
        if (hz_stall) n_stall++;
        @(posedge clk);
        if (fl) begin
            q.delete();
            ov = 0;
        end else begin
            if (iss) begin
                e = q.pop_front();
                decode(e.inst, c, imm);
                ov = 1;
                o_pc = e.pc;
                o_cls = (c < 0) ? 11'h0 : 11'(1 << c);
                o_f3 = e.inst[14:12];
                o_f7 = e.inst[30];
                o_rd = e.inst[11:7];
                o_wbk = !(c inside {BR, ST, FENCE}) && o_rd != 0;
                o_ill = (c < 0);
                o_imm = imm;
                o_r1 = rf(e.inst[19:15], we, wa, wd);
                o_r2 = rf(e.inst[24:20], we, wa, wd);
            end else if (ordy) begin
                ov = 0;
            end
            if (push) q.push_back('{inst: inst, pc: in_pc});
        end
        if (we && wa != 0) mregs[wa] = wd;
        #1;
        check("out_valid", out_valid, ov);
        check("out_pc", out_pc, o_pc);
        check("out_cls", out_cls, o_cls);
        check("out_funct3", out_funct3, o_f3);
        check("out_f7b5", out_f7b5, o_f7);
        check("out_rd", out_rd, o_rd);
        check("out_wbk", out_wbk, o_wbk);
        check("out_illegal", out_illegal, o_ill);
        check("out_imm", out_imm, o_imm);
        check("out_rs1", out_rs1_data, o_r1);
        check("out_rs2", out_rs2_data, o_r2);
        check("fifo_cnt", fifo_cnt, q.size());
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k == 13) return w;
        if (k == 12) begin
            w[1:0] = 2'b10;
            return w;
        end
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[6:0]   = OPS[(k > 10) ? LD : k];
        return w;
    endfunction

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++)
            cycle(0, NOP, ordy, 0, 0, 5'd0, 32'h0);
    endtask

    int s0;
    int max_cnt;

    initial begin
        rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0;
        wb_en = 0; wb_adr = 0; wb_data = 0; out_ready = 0;
        ov = 0; o_pc = 0; o_r1 = 0; o_r2 = 0; o_imm = 0; o_cls = 0;
        o_f3 = 0; o_rd = 0; o_f7 = 0; o_wbk = 0; o_ill = 0;
        mregs[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_cls", out_cls, 0);
        check("rst_ill", out_illegal, 0);
        check("rst_wbk", out_wbk, 0);
        check("rst_stall", hz_stall, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_pc", out_pc, 0);
        check("rst_imm", out_imm, 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_ready", in_ready, 1);

        for (int a = 1; a < 32; a++)
            cycle(0, NOP, 1, 0, 1, 5'(a), $urandom);

        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, NOP, 1, 0, 0, 5'd0, 32'h0);
            if (fifo_cnt > max_cnt) max_cnt = fifo_cnt;
            if (i == 0) check("nop_lat0", out_valid, 0);
            if (i >= 1) check("nop_valid", out_valid, 1);
            if (i >= 1) check("nop_alui", out_cls, 11'(1 << ALUI));
        end
        check("nop_cnt_max", max_cnt, 1);
        idle(2, 1);

        cycle(1, NOP, 0, 0, 0, 5'd0, 32'h0);
        idle(1, 0);
        for (int i = 0; i < 5; i++)
            cycle(1, rnd_inst(), 0, 0, 0, 5'd0, 32'h0);
        check("full_cnt", fifo_cnt, 4);
        check("full_ready", in_ready, 0);
        idle(6, 1);

        s0 = n_stall;
        cycle(1, 32'h0000_A283, 1, 0, 0, 5'd0, 32'h0);
        cycle(1, 32'h0022_8333, 1, 0, 0, 5'd0, 32'h0);
        idle(3, 1);
        check("lu_bubble", n_stall - s0, 1);
        s0 = n_stall;
        cycle(1, 32'h0000_A283, 1, 0, 0, 5'd0, 32'h0);
        cycle(1, 32'h0020_0333, 1, 0, 0, 5'd0, 32'h0);
        idle(3, 1);
        check("lu_x0_none", n_stall - s0, 0);

        cycle(1, 32'h0011_8213, 1, 0, 0, 5'd0, 32'h0);
        cycle(0, NOP, 1, 0, 1, 5'd3, 32'hDEAD_BEEF);
        check("byp_rs1", out_rs1_data, 32'hDEAD_BEEF);
        cycle(1, 32'h0010_0213, 1, 0, 0, 5'd0, 32'h0);
        cycle(0, NOP, 1, 0, 1, 5'd0, 32'hDEAD_BEEF);
        check("byp_x0", out_rs1_data, 0);
        idle(2, 1);

        cycle(1, NOP, 0, 0, 0, 5'd0, 32'h0);
        idle(1, 0);
        for (int i = 0; i < 3; i++)
            cycle(1, rnd_inst(), 0, 0, 0, 5'd0, 32'h0);
        check("fl_pre_cnt", fifo_cnt, 3);
        cycle(1, NOP, 0, 1, 0, 5'd0, 32'h0);
        check("fl_cnt", fifo_cnt, 0);
        check("fl_valid", out_valid, 0);
        idle(2, 1);

        cycle(1, 32'h0020_88B3, 1, 0, 0, 5'd0, 32'h0);
        cycle(1, 32'hFFFF_FFFF, 1, 0, 0, 5'd0, 32'h0);
        check("rve_ill", e_illegal, 1);
        check("rve_cls", e_cls, 11'(1 << ALU));
        check("rv32_ok", out_illegal, 0);
        idle(1, 1);
        check("ones_ill", e_illegal, 1);
        check("ones_cls", e_cls, 0);
        idle(2, 1);

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, rnd_inst(),
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom);

        cycle(1, NOP, 0, 0, 0, 5'd0, 32'h0);
        cycle(1, NOP, 0, 0, 0, 5'd0, 32'h0);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_cnt", fifo_cnt, 0);
        check("arst_cls", out_cls, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
